// File: rtl/register_pipe_if.sv
// Valid/ready bus for register_pipe: upstream word in, downstream word out,
// plus flush and occupancy.
interface register_pipe_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic              out_ready;
  logic              flush;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/register_pipe.sv
// Elastic DEPTH-stage valid/ready register pipe with bubble collapsing,
// synchronous flush and a registered occupancy count.
module register_pipe_stage #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_load,
  input  logic             i_src_vld,
  input  logic [WIDTH-1:0] i_src_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);
  logic             r_vld;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_vld  <= 1'b0;
      r_data <= RESET_VALUE;
    end else if (i_flush) begin
      r_vld  <= 1'b0;
      r_data <= RESET_VALUE;
    end else if (i_load) begin
      r_vld <= i_src_vld;
      // Data only moves with a valid word, so idle-cycle garbage never lands here.
      if (i_src_vld) r_data <= i_src_data;
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;
endmodule

module register_pipe #(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic          clock,
  input  logic          reset,
  register_pipe_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH:0]                w_rdy;
  logic [DEPTH-1:0]              w_vld;
  logic [DEPTH-1:0][WIDTH-1:0]   w_data;
  logic [DEPTH-1:0]              w_src_vld;
  logic [DEPTH-1:0][WIDTH-1:0]   w_src_data;
  logic                          w_in_xfer;
  logic                          w_out_xfer;
  logic [OCC_W-1:0]              r_occ;

  // Ready ripples back from the sink; an empty stage is always ready.
  always_comb begin
    w_rdy        = '0;
    w_rdy[DEPTH] = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--)
      w_rdy[i] = !w_vld[i] || w_rdy[i+1];
  end

  always_comb begin
    w_src_vld     = '0;
    w_src_data    = '0;
    w_src_vld[0]  = bus.in_valid;
    w_src_data[0] = bus.in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_src_vld[i]  = w_vld[i-1];
      w_src_data[i] = w_data[i-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    register_pipe_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clock      (clock),
      .reset      (reset),
      .i_flush    (bus.flush),
      .i_load     (w_rdy[i]),
      .i_src_vld  (w_src_vld[i]),
      .i_src_data (w_src_data[i]),
      .o_vld      (w_vld[i]),
      .o_data     (w_data[i])
    );
  end

  assign w_in_xfer  = bus.in_valid && w_rdy[0];
  assign w_out_xfer = w_vld[DEPTH-1] && bus.out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                       r_occ <= '0;
    else if (bus.flush)               r_occ <= '0;
    else if (w_in_xfer && !w_out_xfer) r_occ <= r_occ + OCC_W'(1);
    else if (w_out_xfer && !w_in_xfer) r_occ <= r_occ - OCC_W'(1);
  end

  assign bus.in_ready  = w_rdy[0];
  assign bus.out_valid = w_vld[DEPTH-1];
  assign bus.out_data  = w_data[DEPTH-1];
  assign bus.occupancy = r_occ;
endmodule

// File: tb/tb_register_pipe.sv
// Scoreboard bench for register_pipe: directed scenarios plus random traffic
// against a queue model (DEPTH=2), and an async-reset scenario (DEPTH=4).
module tb_register_pipe;
  localparam int W = 32;
  localparam int D = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_n, rst_b;
  int   tests = 0, fails = 0;

  register_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();
  register_pipe_if #(.WIDTH(W), .DEPTH(4)) bus4 ();

  register_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VALUE('0)) dut (
    .clock (clock), .reset (rst_n), .bus (bus)
  );
  register_pipe #(.WIDTH(W), .DEPTH(4), .RESET_VALUE('0)) dut4 (
    .clock (clock), .reset (rst_b), .bus (bus4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: the pipe is a FIFO of at most D words; it refuses input
  // only when holding D words while the sink stalls; flush empties it.
  logic [31:0] q[$];
  bit          prev_flush = 0;

  always @(negedge clock) begin
    if (!rst_n) begin
      q.delete();
      prev_flush = 0;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data",  bus.out_data,       32'd0);
      chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    end else begin
      automatic bit exp_rdy = (q.size() < D) || bus.out_ready;
      chk("occupancy", 32'(bus.occupancy), 32'(q.size()));
      chk("in_ready",  32'(bus.in_ready),  32'(exp_rdy));
      if (prev_flush) begin
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_out_data",  bus.out_data,       32'd0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("spurious_out", 32'(bus.out_valid), 32'd0);
        else               chk("out_data", bus.out_data, q.pop_front());
      end
      if (bus.flush) q.delete();
      else if (bus.in_valid && exp_rdy) q.push_back(bus.in_data);
      prev_flush = bus.flush;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; rst_b = 0;
    bus.in_valid = 1; bus.in_data = 32'hDEADBEEF; bus.out_ready = 1; bus.flush = 0;
    bus4.in_valid = 0; bus4.in_data = 0; bus4.out_ready = 0; bus4.flush = 0;
    repeat (3) tick();

    // Reset release: first accepted word reaches the output two edges later
    rst_n = 1; rst_b = 1;
    tick(); chk("lat_v0", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 0;
    tick(); chk("lat_v1", 32'(bus.out_valid), 32'd1);
    chk("lat_d1", bus.out_data, 32'hDEADBEEF);
    repeat (3) tick();

    // Streaming at full rate
    for (int k = 1; k <= 16; k++) begin
      bus.in_valid = 1; bus.in_data = 32'(k);
      tick();
      if (k == 1) chk("stream_first_v", 32'(bus.out_valid), 32'd0);
      else begin
        chk("stream_v", 32'(bus.out_valid), 32'd1);
        chk("stream_d", bus.out_data, 32'(k - 1));
      end
      chk("stream_occ", 32'(bus.occupancy), (k == 1) ? 32'd1 : 32'd2);
    end
    bus.in_valid = 0;
    tick(); chk("stream_last", bus.out_data, 32'h10);
    repeat (3) tick();

    // Back-pressure
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_data = 32'hA; tick();
    bus.in_data = 32'hB; tick();
    bus.in_data = 32'hC;
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_occ", 32'(bus.occupancy), 32'd2);
    tick();
    chk("bp_hold_d", bus.out_data, 32'hA);
    chk("bp_hold_rdy", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1;
    #1 chk("bp_rdy_comb", 32'(bus.in_ready), 32'd1);
    tick(); bus.in_valid = 0;
    chk("bp_d_b", bus.out_data, 32'hB);
    chk("bp_occ2", 32'(bus.occupancy), 32'd2);
    tick(); chk("bp_d_c", bus.out_data, 32'hC);
    tick(); chk("bp_empty", 32'(bus.out_valid), 32'd0);

    // Bubble collapse under stall
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_data = 32'h5; tick();
    bus.in_valid = 0; tick();
    chk("bub_occ1", 32'(bus.occupancy), 32'd1);
    chk("bub_rdy1", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1; bus.in_data = 32'h6; tick();
    chk("bub_occ2", 32'(bus.occupancy), 32'd2);
    chk("bub_rdy2", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 0; bus.out_ready = 1;
    repeat (3) tick();

    // Flush drops the word offered in the same cycle
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_data = 32'h11; tick();
    bus.in_data = 32'h22; tick();
    bus.in_data = 32'h77; bus.out_ready = 1; bus.flush = 1; tick();
    bus.flush = 0; bus.in_valid = 0;
    chk("fl_v", 32'(bus.out_valid), 32'd0);
    chk("fl_occ", 32'(bus.occupancy), 32'd0);
    chk("fl_d", bus.out_data, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("fl_no77", 32'(bus.out_valid), 32'd0);
    end

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.in_data   = $urandom;
      bus.out_ready = ($urandom % 3) != 0;
      bus.flush     = ($urandom % 64) == 0;
      tick();
    end
    bus.in_valid = 0; bus.flush = 0; bus.out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk("drain", 32'(q.size()), 32'd0);

    // Async reset mid-stream on the DEPTH=4 pipe
    bus4.out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      bus4.in_valid = 1; bus4.in_data = 32'hB1 + 32'(k); tick();
    end
    bus4.in_valid = 0; tick();
    chk("ar_pre_v", 32'(bus4.out_valid), 32'd1);
    chk("ar_pre_occ", 32'(bus4.occupancy), 32'd3);
    #2 rst_b = 0;
    #1;
    chk("ar_v", 32'(bus4.out_valid), 32'd0);
    chk("ar_occ", 32'(bus4.occupancy), 32'd0);
    chk("ar_rdy", 32'(bus4.in_ready), 32'd1);
    chk("ar_d", bus4.out_data, 32'd0);
    #2 rst_b = 1;
    tick();
    chk("ar_post_v", 32'(bus4.out_valid), 32'd0);
    bus4.out_ready = 1; bus4.in_valid = 1; bus4.in_data = 32'h55; tick();
    bus4.in_valid = 0;
    tick(); tick();
    chk("ar_nostale", 32'(bus4.out_valid), 32'd0);
    tick();
    chk("ar_new_v", 32'(bus4.out_valid), 32'd1);
    chk("ar_new_d", bus4.out_data, 32'h55);
    tick();
    chk("ar_done", 32'(bus4.occupancy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/register_pipe.md
Name: register_pipe

Overview:
Parametrised elastic register pipeline that generalises the fixed-width I/O register into a WIDTH-bit, DEPTH-stage valid/ready pipe. It has bubble collapsing, synchronous flush and an occupancy count. It sits between datapath blocks, such as the message scheduler and the compression rounds, wherever a registered boundary must tolerate back-pressure without losing or duplicating words.

Parameters:
WIDTH, 32, data width in bits (>=1)
DEPTH, 2, number of register stages (>=1)
RESET_VALUE, 0, value loaded into every data stage on reset and on flush

Ports:
clock  input  1  rising-edge clock
reset  input  1  reset, active-low, asynchronous assert, synchronous-to-clock deassert expected from the reset source
in_valid  input  1  upstream word present
in_data  input  WIDTH  upstream word
in_ready  output  1  pipe accepts in_data this cycle
out_valid  output  1  stage DEPTH-1 holds a word
out_data  output  WIDTH  word in stage DEPTH-1
out_ready  input  1  downstream accepts out_data this cycle
flush  input  1  synchronous clear of all stages
occupancy  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Reset (reset==0, asynchronous): every stage valid=0 and data=RESET_VALUE. Outputs: out_valid=0, out_data=RESET_VALUE, occupancy=0, in_ready=1.
- Each stage i (0..DEPTH-1) has valid_i and data_i. Stage 0 is fed from in_*. Stage DEPTH-1 drives out_*.
- Ready chain is combinational:
  - ready_{DEPTH} = out_ready.
  - ready_i = !valid_i || ready_{i+1}.
  - in_ready = ready_0.
- Stage i update on each rising edge when ready_i==1:
  - valid_i <= valid_{i-1}, data_i <= data_{i-1}.
  - For stage 0, the source is in_valid/in_data.
  - data loads only when the incoming valid is 1. Otherwise data holds its old value.
- When ready_i==0 the stage holds both valid and data.
- Transfers: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Latency: with no stall, a word accepted at edge N appears on out_data after edge N+DEPTH-1, and out_valid is high in the following cycle. Minimum latency is DEPTH cycles from in_valid to out_valid.
- Throughput: 1 word/cycle sustained when out_ready is held at 1.
- Bubble collapsing: an empty stage accepts from upstream even while downstream is stalled. A stalled pipe therefore fills to DEPTH words before in_ready drops.
- Full pipe (all valid) with out_ready=0: in_ready=0, and all state holds.
- Full pipe with out_ready=1: in_ready=1, and simultaneous in and out transfers leave occupancy unchanged.
- occupancy is the registered count of valid stages:
  - +1 on an input transfer only.
  - -1 on an output transfer only.
  - Unchanged when both or neither occur.
  - Never exceeds DEPTH and never underflows.
- flush==1 at an edge: all valid <= 0, data <= RESET_VALUE, occupancy <= 0. flush has priority over any simultaneous transfer, so an input word offered in the flush cycle is dropped.
  - in_ready is not gated by flush, so upstream must treat the word offered in a flush cycle as discarded.
- Reset asserted mid-operation discards all words immediately, without waiting for a clock edge.
- No word is ever duplicated or reordered: output order equals input order.
- X on in_data while in_valid==0 must not propagate to out_data.
- DEPTH==1 degenerates to a single registered stage with in_ready = !out_valid || out_ready.

Test Plan:
- Reset: hold reset=0 with in_valid=1 and in_data=32'hDEADBEEF (WIDTH=32, DEPTH=2, RESET_VALUE=0) -> out_valid=0, out_data=0, occupancy=0, in_ready=1 throughout. After release, the first accepted word appears 2 cycles later.
- Streaming: out_ready=1, feed 0x1,0x2,...,0x10 back-to-back -> out_valid rises 2 cycles after the first accept, outputs are 0x1..0x10 in order with no gaps, occupancy stays at 2 in steady state.
- Back-pressure: out_ready=0, feed 0xA,0xB,0xC -> 0xA and 0xB accepted, occupancy=2, in_ready=0 while 0xC is held. Then raise out_ready -> outputs 0xA,0xB,0xC in order and 0xC is accepted in the same cycle 0xA leaves.
- Bubble collapse: insert one idle input cycle between 0x5 and 0x6 with out_ready=0 -> both words are stored (occupancy=2) and in_ready drops only after 0x6 is accepted.
- Flush: with occupancy=2 and in_valid=1 carrying 0x77, pulse flush for one cycle -> next cycle out_valid=0, occupancy=0, out_data=RESET_VALUE, and 0x77 never appears at the output.
- Async reset mid-stream: assert reset between clock edges while 3 words are in flight (DEPTH=4) -> out_valid and occupancy go to 0 before the next edge. After release, the pipe accepts new data and no stale words appear.
